// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// Each accepted operation is presented to the ALU for one cycle, then held as a response until the owner takes it.
module alu_arbiter #(
    parameter logic [3:0] FLAGS_INIT = 4'b0000,
    parameter logic       PRI_INIT   = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [1:0]  req0_op,
    input  logic        req0_setflags,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [1:0]  req1_op,
    input  logic        req1_setflags,

    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [1:0]  alu_op,
    input  logic [31:0] alu_c,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_carry,
    input  logic        alu_overflow,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_c,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_c,

    output logic [3:0]  flags,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        pri;        // requester that wins when both are valid
    logic        owner;      // requester whose operation is in flight
    logic        gnt_id;
    logic        accept;

    logic [31:0] lat_a;
    logic [31:0] lat_b;
    logic [1:0]  lat_op;
    logic        lat_sf;
    logic [31:0] result;
    logic [3:0]  flags_q;

    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [1:0]  sel_op;
    logic        sel_sf;
    logic        owner_rsp_ready;

    // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        gnt_id     = pri;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;

        case (state)
            IDLE: begin
                if (!(req0_valid && req1_valid)) begin
                    gnt_id = req1_valid;
                end
                // Ready is gated by reset_n so nothing is offered while reset is held.
                if (reset_n && (req0_valid || req1_valid)) begin
                    accept     = 1'b1;
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp0_valid = ~owner;
                rsp1_valid = owner;
                if (owner_rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;

    assign sel_a  = gnt_id ? req1_a        : req0_a;
    assign sel_b  = gnt_id ? req1_b        : req0_b;
    assign sel_op = gnt_id ? req1_op       : req0_op;
    assign sel_sf = gnt_id ? req1_setflags : req0_setflags;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            pri   <= PRI_INIT;
            owner <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                pri   <= ~gnt_id;
                owner <= gnt_id;
            end
        end
    end

    // NOTE: datapath registers are reset too, because the ALU-facing and response outputs must read 0 after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_a   <= '0;
            lat_b   <= '0;
            lat_op  <= '0;
            lat_sf  <= 1'b0;
            result  <= '0;
            flags_q <= FLAGS_INIT;
        end else begin
            if (accept) begin
                lat_a  <= sel_a;
                lat_b  <= sel_b;
                lat_op <= sel_op;
                lat_sf <= sel_sf;
            end
            if (state == EXEC) begin
                result <= alu_c;
                if (lat_sf) begin
                    flags_q <= {alu_negative, alu_zero, alu_carry, alu_overflow};
                end
            end
        end
    end

    // Latched operands only change on accept, so the ALU inputs hold their last values outside EXEC.
    assign alu_a  = lat_a;
    assign alu_b  = lat_b;
    assign alu_op = lat_op;

    assign rsp0_c = result;
    assign rsp1_c = result;
    assign flags  = flags_q;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU on the shared port, directed scenarios, then randomized round-robin traffic
// checked against a transaction-level model of grant order, results and flags.
module tb_alu_arbiter;

    localparam logic [3:0] FLAGS_INIT = 4'b0110;
    localparam logic       PRI_INIT   = 1'b0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];
    logic [1:0]  req_op [2];
    logic [1:0]  req_sf = 2'b00;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_op;
    logic [31:0] alu_c;
    logic        alu_zero;
    logic        alu_negative;
    logic        alu_carry;
    logic        alu_overflow;

    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [31:0] rsp0_c;
    logic [31:0] rsp1_c;
    logic [3:0]  flags;
    logic        busy;

    int          checks = 0;
    int          failures = 0;

    logic        model_pri   = PRI_INIT;
    logic [3:0]  model_flags = FLAGS_INIT;

    alu_arbiter #(
        .FLAGS_INIT(FLAGS_INIT),
        .PRI_INIT  (PRI_INIT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req0_valid   (req_valid[0]),
        .req0_ready   (req_ready[0]),
        .req0_a       (req_a[0]),
        .req0_b       (req_b[0]),
        .req0_op      (req_op[0]),
        .req0_setflags(req_sf[0]),
        .req1_valid   (req_valid[1]),
        .req1_ready   (req_ready[1]),
        .req1_a       (req_a[1]),
        .req1_b       (req_b[1]),
        .req1_op      (req_op[1]),
        .req1_setflags(req_sf[1]),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_c        (alu_c),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .rsp0_valid   (rsp_valid[0]),
        .rsp0_ready   (rsp_ready[0]),
        .rsp0_c       (rsp0_c),
        .rsp1_valid   (rsp_valid[1]),
        .rsp1_ready   (rsp_ready[1]),
        .rsp1_c       (rsp1_c),
        .flags        (flags),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Returns {N, Z, C, V, result}. Logic ops return C=a[0], V=b[31] so flag pass-through is observable.
    function automatic logic [35:0] alu_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] wide;
        logic [31:0] r;
        logic        c;
        logic        v;
        case (op)
            2'b00: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[31:0];
                c = wide[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            2'b01: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            2'b10: begin
                r = a | b;
                c = a[0];
                v = b[31];
            end
            default: begin
                r = a & b;
                c = a[0];
                v = b[31];
            end
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    always_comb begin
        {alu_negative, alu_zero, alu_carry, alu_overflow, alu_c} = alu_model(alu_op, alu_a, alu_b);
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic sf);
        req_op[id] = op;
        req_a[id]  = a;
        req_b[id]  = b;
        req_sf[id] = sf;
    endtask

    // Starts at a falling edge with the arbiter idle; ends at the falling edge right after the response handshake.
    task automatic transact(input logic [1:0] mask, input int stall, output int g);
        logic [31:0] sa;
        logic [31:0] sb;
        logic [1:0]  sop;
        logic        ssf;
        logic [35:0] r;
        logic [31:0] exp_c;

        req_valid = mask;
        #1;
        g = (mask == 2'b11) ? int'(model_pri) : (mask[1] ? 1 : 0);
        check("grant_ready", 32'(req_ready), 32'(1) << g);
        check("idle_busy", 32'(busy), 32'd0);
        sa  = req_a[g];
        sb  = req_b[g];
        sop = req_op[g];
        ssf = req_sf[g];
        r     = alu_model(sop, sa, sb);
        exp_c = r[31:0];
        model_pri = (g == 0);

        @(negedge clk);
        // The accepted requester moves on; the arbiter must not look at these inputs again.
        req_valid[g] = 1'b0;
        req_a[g]     = pick_operand();
        req_b[g]     = pick_operand();
        req_op[g]    = 2'($urandom);
        req_sf[g]    = 1'($urandom);
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_ready", 32'(req_ready), 32'd0);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_alu_a", alu_a, sa);
        check("exec_alu_b", alu_b, sb);
        check("exec_alu_op", 32'(alu_op), 32'(sop));
        if (ssf) begin
            model_flags = r[35:32];
        end
        rsp_ready[g]     = 1'b0;
        rsp_ready[1 - g] = 1'b1;

        for (int i = 0; i <= stall; i++) begin
            @(negedge clk);
            check("resp_valid", 32'(rsp_valid), 32'(1) << g);
            check("resp_c", (g == 0) ? rsp0_c : rsp1_c, exp_c);
            check("resp_flags", 32'(flags), 32'(model_flags));
            check("resp_ready", 32'(req_ready), 32'd0);
            if (i == stall) begin
                rsp_ready[g] = 1'b1;
            end
        end

        @(negedge clk);
        rsp_ready = 2'b00;
        check("post_busy", 32'(busy), 32'd0);
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_c_hold", (g == 0) ? rsp0_c : rsp1_c, exp_c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          g;
        logic [1:0]  pending;
        logic [1:0]  mask;

        set_req(0, 2'b00, 32'd0, 32'd0, 1'b0);
        set_req(1, 2'b00, 32'd0, 32'd0, 1'b0);

        // Reset state, with both requesters valid to show ready stays low.
        req_valid = 2'b11;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_flags", 32'(flags), 32'(FLAGS_INIT));
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_rsp0_c", rsp0_c, 32'd0);
        req_valid = 2'b00;
        reset_n = 1'b1;
        @(negedge clk);

        // Signed overflow on ADD.
        set_req(0, 2'b00, 32'h7FFF_FFFF, 32'd1, 1'b1);
        transact(2'b01, 0, g);
        check("add_flags", 32'(flags), 32'(4'b1001));
        check("add_result", rsp0_c, 32'h8000_0000);

        // SUB without setflags leaves flags alone.
        set_req(1, 2'b01, 32'd5, 32'd5, 1'b0);
        transact(2'b10, 0, g);
        check("sub_nsf_flags", 32'(flags), 32'(4'b1001));
        check("sub_result", rsp1_c, 32'd0);

        // Logic ops.
        set_req(0, 2'b10, 32'h0000_F0F0, 32'h0000_0F0F, 1'b1);
        transact(2'b01, 0, g);
        check("orr_result", rsp0_c, 32'h0000_FFFF);
        set_req(1, 2'b11, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1);
        transact(2'b10, 0, g);
        check("and_result", rsp1_c, 32'd0);
        check("and_flags", 32'(flags), 32'(4'b0100));

        // Contention: both valid every cycle, grants must alternate.
        for (int k = 0; k < 4; k++) begin
            transact(2'b11, 0, g);
        end

        // Backpressure on requester 0 while requester 1 waits.
        transact(2'b11, 5, g);
        transact(2'b10, 0, g);

        // Nothing valid: the arbiter stays idle.
        req_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_hold_busy", 32'(busy), 32'd0);
            check("idle_hold_ready", 32'(req_ready), 32'd0);
        end

        // Reset during RESP aborts the response and restores flags.
        set_req(0, 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1);
        req_valid = 2'b01;
        #1;
        check("abort_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk);
        check("abort_resp_valid", 32'(rsp_valid), 32'd1);
        check("abort_resp_flags", 32'(flags), 32'(4'b0111));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_flags", 32'(flags), 32'(FLAGS_INIT));
        check("abort_rsp0_c", rsp0_c, 32'd0);
        check("abort_alu_a", alu_a, 32'd0);
        model_pri   = PRI_INIT;
        model_flags = FLAGS_INIT;
        @(negedge clk);
        reset_n = 1'b1;
        set_req(1, 2'b01, 32'd3, 32'd7, 1'b1);
        transact(2'b10, 0, g);

        // Randomized traffic; a requester not granted keeps its request up unchanged.
        pending = 2'b00;
        for (int k = 0; k < 40; k++) begin
            mask = pending | 2'($urandom);
            if (mask == 2'b00) begin
                mask[$urandom_range(0, 1)] = 1'b1;
            end
            transact(mask, $urandom_range(0, 2), g);
            pending = mask;
            pending[g] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
